// File: rtl/bpsk_pkg.sv
// Shared types and sine table generator for the BPSK transmit path.
// Table entries are round-to-nearest of A*sin(k*45deg) with A = 2^(width-1)-1.
package bpsk_pkg;

   typedef enum logic {IDLE, SEND} tx_state_t;

   localparam int LUT_DEPTH = 8;
   localparam int PHASE_W   = $clog2(LUT_DEPTH);

   function automatic int sine_lut(input logic [PHASE_W-1:0] idx, input int width);
      longint amp;
      longint diag;
      amp  = (longint'(1) << (width - 1)) - 64'sd1;
      // sin(45deg) in micro-units, rounded half up; amp is always positive
      diag = (amp * 64'sd707107 + 64'sd500000) / 64'sd1000000;
      case (idx)
         3'd0, 3'd4: sine_lut = 0;
         3'd1, 3'd3: sine_lut = int'(diag);
         3'd2:       sine_lut = int'(amp);
         3'd5, 3'd7: sine_lut = -int'(diag);
         default:    sine_lut = -int'(amp);
      endcase
   endfunction

endpackage

// File: rtl/bpsk_sine_lut.sv
// Combinational carrier table: phase index to signed sample, zero latency,
// no flow control.
module bpsk_sine_lut
   import bpsk_pkg::*;
#(
   parameter int DATA_WIDTH = 5
) (
   input  logic [PHASE_W-1:0]           phase,
   output logic signed [DATA_WIDTH-1:0] sample
);

   always_comb begin
      sample = DATA_WIDTH'(sine_lut(phase, DATA_WIDTH));
   end

endmodule

// File: rtl/bpsk_tx_modulator.sv
// BPSK modulator: each accepted bit becomes CYCLES_PER_SYMBOL signed carrier periods, one sample per
// sample_en, output registered 1 cycle; bit_ready only in IDLE or on a symbol's last strobe.
module bpsk_tx_modulator
   import bpsk_pkg::*;
#(
   parameter int DATA_WIDTH        = 5,
   parameter int CYCLES_PER_SYMBOL = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bit_in,
   input  logic                         bit_valid,
   output logic                         bit_ready,
   input  logic                         sample_en,
   output logic signed [DATA_WIDTH-1:0] sample_out,
   output logic                         sample_valid,
   output logic                         busy
);

   localparam int CYC_W = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
   localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(CYCLES_PER_SYMBOL - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(LUT_DEPTH - 1);

   tx_state_t                    state_q, state_d;
   logic [PHASE_W-1:0]           phase_q, phase_d;
   logic [CYC_W-1:0]             cyc_q, cyc_d;
   logic                         sym_q, sym_d;
   logic signed [DATA_WIDTH-1:0] sample_out_q, sample_out_d;
   logic                         sample_valid_q, sample_valid_d;

   logic signed [DATA_WIDTH-1:0] lut_sample;
   logic                         last_sample;
   logic                         accept;

   bpsk_sine_lut #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_lut (
      .phase  (phase_q),
      .sample (lut_sample)
   );

   assign last_sample = (phase_q == PHASE_LAST) && (cyc_q == CYC_LAST);
   assign bit_ready   = !rst && ((state_q == IDLE) || (sample_en && last_sample));
   assign accept      = bit_valid && bit_ready;

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      cyc_d          = cyc_q;
      sym_d          = sym_q;
      sample_out_d   = sample_out_q;
      sample_valid_d = sample_en;

      case (state_q)
         IDLE: begin
            if (sample_en) begin
               sample_out_d = '0;
            end
            if (accept) begin
               sym_d   = bit_in;
               phase_d = '0;
               cyc_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (sample_en) begin
               sample_out_d = sym_q ? lut_sample : -lut_sample;
               phase_d      = phase_q + PHASE_W'(1);
               if (phase_q == PHASE_LAST) begin
                  cyc_d = cyc_q + CYC_W'(1);
               end
               // Chain straight into the next symbol so the carrier has no gap
               if (last_sample) begin
                  cyc_d   = '0;
                  phase_d = '0;
                  if (accept) begin
                     sym_d = bit_in;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         phase_q        <= '0;
         cyc_q          <= '0;
         sym_q          <= 1'b0;
         sample_out_q   <= '0;
         sample_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         cyc_q          <= cyc_d;
         sym_q          <= sym_d;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= sample_valid_d;
      end
   end

   assign sample_out   = sample_out_q;
   assign sample_valid = sample_valid_q;
   assign busy         = (state_q == SEND);

endmodule
